ppwm_prog_tx: RTL and testbench

PPWM_PROG_TX -- requirements
Module: ppwm_prog_tx

---
 rtl/ppwm_prog_tx_if.sv | 10 +
 rtl/ppwm_prog_tx.sv | 65 ++++++
 tb/tb_ppwm_prog_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ppwm_prog_tx_if.sv
// ppwm_prog_tx_if: word-feed handshake between the program source and the serializer
interface ppwm_prog_tx_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] word_i;
  logic             word_valid_i;
  logic             word_ready_o;
  modport master (output word_i, word_valid_i, input word_ready_o);
  modport slave (input word_i, word_valid_i, output word_ready_o);
endinterface

// File: rtl/ppwm_prog_tx.sv
// ppwm_prog_tx: serializes a DEPTH-word program onto the single-wire PWM programming line
module ppwm_prog_tx #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 16,
  parameter int GAP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  ppwm_prog_tx_if.slave wif,
  output logic          data_o,
  output logic          busy_o,
  output logic          done_o
);
  localparam int WCW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int BCW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [WCW-1:0] WORD_LAST = WCW'(DEPTH - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [2:0] GAP_LAST = 3'(GAP > 0 ? GAP - 1 : 0);
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT_WORD, ST_START, ST_DATA, ST_GAP} state_t;
  state_t state, next;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0] bit_cnt;
  logic [2:0] gap_cnt;
  logic [WCW-1:0] word_cnt;
  logic bit_last, last_word, frame_end;
  state_t end_next;
  // state register; reset aborts any transfer and returns to idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= next;
  // next state and outputs, decoded only from registered state so inputs never reach outputs
  always_comb begin
    bit_last = bit_cnt == BIT_LAST;
    last_word = word_cnt == WORD_LAST;
    frame_end = (state == ST_DATA && bit_last && GAP == 0) || (state == ST_GAP && gap_cnt == GAP_LAST);
    end_next = last_word ? ST_IDLE : ST_WAIT_WORD;
    next = state;
    case (state)
      ST_IDLE:      next = start_i ? ST_WAIT_WORD : ST_IDLE;
      ST_WAIT_WORD: next = wif.word_valid_i ? ST_START : ST_WAIT_WORD;
      ST_START:     next = ST_DATA;
      ST_DATA:      next = frame_end ? end_next : bit_last ? ST_GAP : ST_DATA;
      ST_GAP:       next = frame_end ? end_next : ST_GAP;
      default:      next = ST_IDLE;
    endcase
    wif.word_ready_o = state == ST_WAIT_WORD;
    data_o = state == ST_START || (state == ST_DATA && shreg[WIDTH-1]);
    done_o = frame_end && last_word;
    busy_o = state != ST_IDLE && !done_o;
  end
  // shift register, per-frame bit/gap counters and the program word counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shreg <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      word_cnt <= '0;
    end else begin
      shreg <= (state == ST_WAIT_WORD && wif.word_valid_i) ? wif.word_i : state == ST_DATA ? shreg << 1 : shreg;
      bit_cnt <= (state == ST_DATA && !bit_last) ? bit_cnt + 1'b1 : '0;
      gap_cnt <= state == ST_GAP ? gap_cnt + 1'b1 : '0;
      word_cnt <= state == ST_IDLE ? '0 : (frame_end && !last_word) ? word_cnt + 1'b1 : word_cnt;
    end
endmodule

// File: tb/tb_ppwm_prog_tx.sv
// tb_ppwm_prog_tx: directed vector table plus program-level sequences for ppwm_prog_tx
module tb_ppwm_prog_tx;
  logic clk = 0, rst_n, start, start0, valid;
  logic [6:0] word;
  logic data, busy, done, data0, busy0, done0;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  ppwm_prog_tx_if #(.WIDTH(7)) pif ();
  ppwm_prog_tx_if #(.WIDTH(7)) pif0 ();
  assign pif.word_i = word;
  assign pif.word_valid_i = valid;
  assign pif0.word_i = word;
  assign pif0.word_valid_i = valid;
  ppwm_prog_tx dut (.clk(clk), .rst_n(rst_n), .start_i(start), .wif(pif), .data_o(data), .busy_o(busy), .done_o(done));
  ppwm_prog_tx #(.WIDTH(7), .DEPTH(4), .GAP(0)) dut0 (.clk(clk), .rst_n(rst_n), .start_i(start0), .wif(pif0), .data_o(data0), .busy_o(busy0), .done_o(done0));
  typedef struct {
    logic st;
    logic vl;
    logic [6:0] wd;
    logic [3:0] exp;
  } vec_t;
  vec_t tv[15];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; start = 0; start0 = 0; valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic run_prog(input bit sel, input int depth, input int exp_cyc, input int stall_at, input int stall_len, input bit poke);
    int idx, stalled, frames, rxc;
    logic [6:0] rxw;
    logic d, r, b, dn;
    bit fin;
    idx = 0; stalled = 0; frames = 0; rxc = -1; rxw = '0; fin = 0;
    @(negedge clk);
    if (sel) start0 = 1; else start = 1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      if (cyc > 1) @(negedge clk);
      d = sel ? data0 : data;
      r = sel ? pif0.word_ready_o : pif.word_ready_o;
      b = sel ? busy0 : busy;
      dn = sel ? done0 : done;
      if (rxc >= 0) begin
        rxw = {rxw[5:0], d};
        rxc++;
        if (rxc == 7) begin
          chk("frame_word", 32'(rxw), 32'(frames));
          frames++;
          rxc = -1;
        end
      end else if (d) rxc = 0;
      start = 0; start0 = 0;
      if (r && idx == stall_at && stalled < stall_len) begin
        valid = 0;
        stalled++;
        chk("stall_data", 32'(d), 0);
      end else if (r) begin
        valid = 1; word = 7'(idx); idx++;
      end else begin
        valid = 1; word = 7'h7f;
      end
      if (poke && !r && idx == 9) start = 1;
      if (dn) begin
        chk("done_cycle", cyc, exp_cyc);
        chk("frame_count", frames, depth);
        chk("busy_at_done", 32'(b), 0);
        if (poke) start = 1;
        fin = 1;
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 0; start0 = 0; valid = 0;
      chk("back_to_idle", sel ? {pif0.word_ready_o, busy0, done0} : {pif.word_ready_o, busy, done}, 0);
    end
  endtask
  initial begin
    int n;
    rst_n = 0; start = 0; start0 = 0; valid = 0; word = '0;
    tv[0]  = '{1'b1, 1'b0, 7'h00, 4'b0110};
    tv[1]  = '{1'b1, 1'b1, 7'h55, 4'b1010};
    tv[2]  = '{1'b0, 1'b1, 7'h00, 4'b1010};
    tv[3]  = '{1'b0, 1'b1, 7'h00, 4'b0010};
    tv[4]  = '{1'b0, 1'b1, 7'h00, 4'b1010};
    tv[5]  = '{1'b0, 1'b1, 7'h00, 4'b0010};
    tv[6]  = '{1'b0, 1'b1, 7'h00, 4'b1010};
    tv[7]  = '{1'b0, 1'b1, 7'h00, 4'b0010};
    tv[8]  = '{1'b0, 1'b1, 7'h00, 4'b1010};
    tv[9]  = '{1'b0, 1'b1, 7'h00, 4'b0010};
    tv[10] = '{1'b0, 1'b1, 7'h00, 4'b0110};
    tv[11] = '{1'b0, 1'b0, 7'h00, 4'b0110};
    tv[12] = '{1'b0, 1'b1, 7'h2a, 4'b1010};
    tv[13] = '{1'b0, 1'b0, 7'h00, 4'b0010};
    tv[14] = '{1'b0, 1'b0, 7'h00, 4'b1010};
    #7;
    chk("reset_outputs", {data, pif.word_ready_o, busy, done, data0, pif0.word_ready_o, busy0, done0}, 0);
    @(negedge clk);
    rst_n = 1;
    foreach (tv[i]) begin
      start = tv[i].st; valid = tv[i].vl; word = tv[i].wd;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {data, pif.word_ready_o, busy, done}, tv[i].exp);
    end
    do_reset();
    run_prog(0, 16, 160, -1, 0, 0);
    do_reset();
    run_prog(0, 16, 165, 3, 5, 0);
    do_reset();
    run_prog(0, 16, 160, -1, 0, 1);
    do_reset();
    run_prog(1, 4, 36, -1, 0, 0);
    do_reset();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      if (c > 0) @(negedge clk);
      valid = 1; word = 7'h7f;
      if (pif.word_ready_o) n++;
    end
    chk("abort_handshakes", n, 6);
    repeat (5) @(negedge clk);
    chk("pre_abort_data", {data, busy}, 2'b11);
    rst_n = 0;
    #1;
    chk("abort_async", {data, pif.word_ready_o, busy, done}, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1;
      chk("no_resume", {data, pif.word_ready_o, busy, done}, 0);
    end
    run_prog(0, 16, 160, -1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
